inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, queue entries; power of two, >=2.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: imem_req  output  1  fetch request to instruction memory.
REQ-006 Port: imem_addr  output  32  word-aligned fetch address.
REQ-007 Port: imem_ack  input  1  request completed; imem_rdata valid this cycle.
REQ-008 Port: imem_rdata  input  32  fetched instruction.
REQ-009 Port: redirect  input  1  taken branch/jump from datapath; flush and refetch.
REQ-010 Port: redirect_pc  input  32  new fetch address.
REQ-011 Port: out_valid  output  1  head entry available to datapath.
REQ-012 Port: out_ready  input  1  datapath accepts head entry.
REQ-013 Port: out_inst  output  32  head instruction.
REQ-014 Port: out_pc  output  32  address of head instruction.
REQ-015 Port: fetch_misalign  output  1  sticky misaligned-redirect flag.

Function
REQ-016 Memory handshake SHALL be req/ack: imem_req and imem_addr held stable from assertion until the cycle imem_ack=1; ack in the first req cycle (zero-wait) is legal.
REQ-017 FSM states SHALL be IDLE, REQ, DROP, HALT; imem_req=1 exactly in REQ and DROP.
REQ-018 IDLE -> REQ SHALL occur when count<DEPTH.
REQ-019 In REQ with imem_ack=1 and redirect=0, the block SHALL push {imem_rdata, fetch_pc}, set fetch_pc=fetch_pc+4 (mod 2^32), and stay in REQ if next count<DEPTH, else go to IDLE.
REQ-020 Zero-wait memory with out_ready=1 SHALL sustain one instruction per cycle.
REQ-021 out_valid SHALL equal (count!=0); out_inst/out_pc SHALL show the head entry combinationally.
REQ-022 Pop SHALL occur when out_valid=1 and out_ready=1; push and pop in one cycle leave count unchanged; no push while count=DEPTH.
REQ-023 redirect SHALL take priority over all events: count=0 next cycle, fetch_pc=redirect_pc; a pop in the same cycle counts as accepted by the consumer.
REQ-024 redirect in REQ with imem_ack=0 SHALL go to DROP; otherwise (IDLE, or REQ with ack) SHALL go to REQ; data acked in the redirect cycle SHALL be discarded.
REQ-025 DROP SHALL hold the old request until imem_ack, discard imem_rdata, then go to REQ at fetch_pc; a further redirect in DROP updates fetch_pc only.
REQ-026 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 rst=0 SHALL immediately force state=IDLE, count=0, pointers=0, fetch_pc=RESET_PC, fetch_misalign=0, hence imem_req=0, out_valid=0.
REQ-028 After rst deasserts, imem_req SHALL rise the cycle after the first rising edge, with imem_addr=RESET_PC.
REQ-029 Reset mid-request SHALL abandon the outstanding request; the memory is reset by the same rst.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN: when defined, redirect with redirect_pc[1:0]!=0 SHALL flush, set fetch_misalign=1, drain any outstanding request via DROP, then enter HALT; HALT issues no requests, holds out_valid=0, ignores redirect, and is left only by reset.
REQ-031 When FETCH_MISALIGN_CHECK_EN is undefined, redirect_pc[1:0] SHALL be treated as 2'b00 and fetch_misalign SHALL be tied 0.

Verification
REQ-032 Reset release, zero-wait memory returning addr+1, out_ready=1 -> imem_addr 0,4,8,...; out_pc/out_inst 0/1, 4/5, 8/9 on consecutive cycles.
REQ-033 out_ready=0, DEPTH=4 -> exactly 4 pushes (PCs 0,4,8,12), imem_req drops, count holds 4; out_ready=1 for 1 cycle -> one pop, one new fetch at 16.
REQ-034 3-cycle-latency memory, redirect to 0x100 in 2nd wait cycle -> req held at old addr until ack, that data discarded, next req addr 0x100, first out_pc 0x100.
REQ-035 Redirect to 0x40 in same cycle as ack with count=2 -> acked word dropped, out_valid=0 next cycle, next out_pc 0x40.
REQ-036 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> fetch_misalign=1, HALT, no imem_req until rst=0; without macro, fetches resume at 0x100.
REQ-037 rst=0 asserted mid-wait with count=3 -> out_valid and imem_req 0 immediately; after release, refetch from RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue_if
// Description : Bundle of the instruction-fetch queue's bus signals: the
//               req/ack instruction-memory port, the redirect port from the
//               datapath and the head-of-queue valid/ready port.
//               master : the fetch queue itself.
//               slave  : the environment (memory + datapath).
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_queue_if;

    // Instruction memory side
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Redirect from the datapath
    logic        redirect;
    logic [31:0] redirect_pc;

    // Head entry towards the datapath
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    // Sticky misaligned-redirect indication
    logic        fetch_misalign;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output fetch_misalign
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  fetch_misalign
    );

endinterface : inst_fetch_queue_if
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Instruction prefetch queue. Issues word-aligned req/ack
//               fetches from RESET_PC onwards, buffers up to DEPTH
//               {instruction, pc} pairs and presents the oldest one to the
//               datapath with a valid/ready handshake. A redirect flushes the
//               queue and restarts fetching at the new address; a request
//               still in flight at that moment is completed and its data is
//               thrown away (DROP state).
//               Optional feature macro: FETCH_MISALIGN_CHECK_EN
//                 defined   - a redirect to a non-word-aligned address sets
//                             the sticky fetch_misalign flag and halts
//                             fetching until reset.
//                 undefined - the two low redirect address bits are ignored
//                             and fetch_misalign is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic            clk,
    input  wire logic            rst,        // asynchronous, active low
    inst_fetch_queue_if.master   fetch_if
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;   // address of the next word to queue
    logic [31:0]        req_addr_q, req_addr_d;   // address currently on the memory bus
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;

    logic [31:0]        inst_mem_q [DEPTH];
    logic [31:0]        pc_mem_q   [DEPTH];

    logic               w_redirect;
    logic [31:0]        w_redirect_pc;
    logic               w_halting;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    // HALT is only left through reset, so redirects are meaningless there.
    assign w_redirect    = fetch_if.redirect && (state_q != ST_HALT);
    assign w_redirect_pc = fetch_if.redirect_pc & 32'hFFFF_FFFC;

    assign w_full = (count_q == FULL_CNT);
    assign w_pop  = (count_q != '0) && fetch_if.out_ready;
    // Data returned in a redirect cycle belongs to the abandoned path.
    assign w_push = (state_q == ST_REQ) && fetch_if.imem_ack && !w_redirect && !w_full;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic w_misalign;
    logic misalign_q;

    assign w_misalign = w_redirect && (fetch_if.redirect_pc[1:0] != 2'b00);
    // Once set (or being set this cycle) the FSM heads for HALT.
    assign w_halting  = misalign_q || w_misalign;
    assign fetch_if.fetch_misalign = misalign_q;

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_q || w_misalign;
        end
    end
`else
    assign w_halting = 1'b0;
    assign fetch_if.fetch_misalign = 1'b0;
`endif

    // Queue bookkeeping: redirect flushes everything, else push/pop update.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (w_redirect) begin
            fetch_pc_d = w_redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (w_push) begin
                // Power-of-two depth: pointer wrap is the natural overflow.
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
        end
    end

    // Fetch FSM next state and the address to present on the memory bus.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_redirect) begin
                    state_d = w_halting ? ST_HALT : ST_REQ;
                end else if (!w_full) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_redirect) begin
                    // An unfinished request must still be completed on the bus.
                    if (fetch_if.imem_ack) begin
                        state_d = w_halting ? ST_HALT : ST_REQ;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else if (fetch_if.imem_ack) begin
                    state_d = (count_d != FULL_CNT) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (fetch_if.imem_ack) begin
                    state_d = w_halting ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The bus address follows fetch_pc except while an abandoned request
        // is being drained, where it must stay frozen until the ack.
        req_addr_d = (state_d == ST_DROP) ? req_addr_q : fetch_pc_d;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            inst_mem_q[wr_ptr_q] <= fetch_if.imem_rdata;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign fetch_if.imem_req  = (state_q == ST_REQ) || (state_q == ST_DROP);
    assign fetch_if.imem_addr = req_addr_q;
    assign fetch_if.out_valid = (count_q != '0);
    assign fetch_if.out_inst  = inst_mem_q[rd_ptr_q];
    assign fetch_if.out_pc    = pc_mem_q[rd_ptr_q];

endmodule : inst_fetch_queue
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Self-checking bench for inst_fetch_queue: a directed vector
//               table from reset, hand-written redirect/reset sequences and a
//               randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_queue_if bus_if ();

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .fetch_if (bus_if)
    );

    // ---------------- memory model: latency in wait cycles before ack ------
    int          mem_lat  = 0;
    bit          mem_rand = 1'b0;
    logic [31:0] salt     = 32'h0;
    logic [2:0]  wcnt;
    logic [1:0]  cur_lat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt    <= 3'd0;
            cur_lat <= 2'(mem_lat);
        end else if (bus_if.imem_req) begin
            if (bus_if.imem_ack) begin
                wcnt    <= 3'd0;
                cur_lat <= mem_rand ? 2'($urandom_range(0, 3)) : 2'(mem_lat);
            end else begin
                wcnt <= wcnt + 3'd1;
            end
        end
    end

    assign bus_if.imem_ack   = bus_if.imem_req && ({1'b0, cur_lat} <= wcnt);
    assign bus_if.imem_rdata = bus_if.imem_addr + 32'd1 + salt;

    // ---------------- checking ---------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table --------------------------------
    // Each row: check the expected outputs at this falling edge, then drive
    // rst_n/out_ready for the next rising edge. Memory is zero-wait.
    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[17];

    // ---------------- reference model --------------------------------------
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    bit          m_active;
    bit          m_discard;
    bit          m_flag;

    task automatic model_reset();
        mq.delete();
        m_fpc     = RESET_PC;
        m_addr    = RESET_PC;
        m_active  = 1'b0;
        m_discard = 1'b0;
        m_flag    = 1'b0;
    endtask

    // One clock of behaviour, from the inputs that will be seen at the edge.
    task automatic model_step();
        logic ack;
        int   size_now;
        bit   pop, eff, mis, cont, nxt;
        ack      = bus_if.imem_ack;
        size_now = mq.size();
        pop      = (size_now > 0) && bus_if.out_ready;
        eff      = bus_if.redirect && !m_flag;
        mis      = eff && MIS_EN && (bus_if.redirect_pc[1:0] != 2'b00);
        cont     = m_active && !ack;
        if (pop) void'(mq.pop_front());
        if (m_active && ack && !m_discard && !eff) begin
            mq.push_back('{inst: m_addr + 32'd1 + salt, pc: m_addr});
            m_fpc = m_fpc + 32'd4;
        end
        if (eff) begin
            mq.delete();
            m_fpc = bus_if.redirect_pc & 32'hFFFF_FFFC;
            if (mis) m_flag = 1'b1;
        end
        if (cont && eff) m_discard = 1'b1;
        if (m_active && ack) m_discard = 1'b0;
        if (cont)          nxt = 1'b1;
        else if (m_flag)   nxt = 1'b0;
        else if (m_active) nxt = (mq.size() < DEPTH);
        else               nxt = eff || (size_now < DEPTH);
        if (nxt && !cont) m_addr = m_fpc;
        m_active = nxt;
    endtask

    task automatic model_check();
        chk("rnd_valid", 32'(bus_if.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("rnd_pc",   bus_if.out_pc,   mq[0].pc);
            chk("rnd_inst", bus_if.out_inst, mq[0].inst);
        end
        chk("rnd_req", 32'(bus_if.imem_req), 32'(m_active));
        if (m_active) chk("rnd_addr", bus_if.imem_addr, m_addr);
        chk("rnd_misalign", 32'(bus_if.fetch_misalign), 32'(m_flag));
    endtask

    // Reset with the given fixed memory latency; returns at the falling edge
    // where reset is released (no rising edge seen yet out of reset).
    task automatic do_reset(input int lat);
        mem_lat            = lat;
        bus_if.out_ready   = 1'b0;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 32'h0;
        rst_n              = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          found;
        int          hits;
        int          vhits;
        logic [31:0] rpc;

        //           rst ready req addr          valid pc            inst
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0,  32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0,  32'h1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4,  32'h5};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8,  32'h9};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'hC,  32'hD};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0,  32'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h4,  1'b1, 32'h0,  32'h1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h8,  1'b1, 32'h0,  32'h1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'hC,  1'b1, 32'h0,  32'h1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  32'h1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h5};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h4,  32'h5};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h5};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h5};

        bus_if.out_ready   = 1'b0;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 32'h0;
        mem_lat            = 0;
        repeat (3) @(negedge clk);

        // ---- table: streaming, back-pressure, refill after one pop ----
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("vec%0d_req", i),   32'(bus_if.imem_req),  32'(vecs[i].exp_req));
            chk($sformatf("vec%0d_valid", i), 32'(bus_if.out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_req)
                chk($sformatf("vec%0d_addr", i), bus_if.imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i),   bus_if.out_pc,   vecs[i].exp_pc);
                chk($sformatf("vec%0d_inst", i), bus_if.out_inst, vecs[i].exp_inst);
            end
            rst_n            = vecs[i].rst_n;
            bus_if.out_ready = vecs[i].ready;
            @(negedge clk);
        end

        // ---- redirect in the second wait cycle of a 3-wait request ----
        do_reset(3);
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("lat3_first_req",  32'(bus_if.imem_req), 32'd1);
        chk("lat3_first_addr", bus_if.imem_addr, RESET_PC);
        @(negedge clk);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h100;
        @(negedge clk);
        bus_if.redirect = 1'b0;
        chk("lat3_drop_req",   32'(bus_if.imem_req),  32'd1);
        chk("lat3_drop_addr",  bus_if.imem_addr,      32'h0);
        chk("lat3_drop_valid", 32'(bus_if.out_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.imem_req && bus_if.imem_addr != 32'h0) begin
                found = 1'b1;
                break;
            end
            if (bus_if.out_valid) break;
        end
        chk("lat3_newreq_seen",  32'(found), 32'd1);
        chk("lat3_newreq_addr",  bus_if.imem_addr, 32'h100);
        chk("lat3_newreq_valid", 32'(bus_if.out_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("lat3_valid_seen", 32'(found), 32'd1);
        chk("lat3_first_pc",   bus_if.out_pc,   32'h100);
        chk("lat3_first_inst", bus_if.out_inst, 32'h101);

        // ---- redirect in the same cycle as an ack with two queued ----
        do_reset(1);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_if.imem_req && bus_if.imem_ack && bus_if.imem_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        chk("ackredir_seen",  32'(found), 32'd1);
        chk("ackredir_valid", 32'(bus_if.out_valid), 32'd1);
        chk("ackredir_head",  bus_if.out_pc, 32'h0);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h40;
        @(negedge clk);
        bus_if.redirect = 1'b0;
        chk("ackredir_flushed", 32'(bus_if.out_valid), 32'd0);
        chk("ackredir_req",     32'(bus_if.imem_req),  32'd1);
        chk("ackredir_addr",    bus_if.imem_addr,      32'h40);
        bus_if.out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("ackredir_valid_seen", 32'(found), 32'd1);
        chk("ackredir_pc",   bus_if.out_pc,   32'h40);
        chk("ackredir_inst", bus_if.out_inst, 32'h41);

        // ---- misaligned redirect while a request is waiting ----
        do_reset(1);
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("mis_wait_req", 32'(bus_if.imem_req && !bus_if.imem_ack), 32'd1);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h102;
        @(negedge clk);
        bus_if.redirect = 1'b0;
        chk("mis_flag",     32'(bus_if.fetch_misalign), 32'(MIS_EN));
        chk("mis_drop_req", 32'(bus_if.imem_req),       32'd1);
        chk("mis_valid0",   32'(bus_if.out_valid),      32'd0);
        if (MIS_EN) begin
            @(negedge clk);
            hits  = 0;
            vhits = 0;
            for (int i = 0; i < 12; i++) begin
                if (bus_if.imem_req)  hits++;
                if (bus_if.out_valid) vhits++;
                bus_if.redirect    = (i == 3);
                bus_if.redirect_pc = 32'h200;
                @(negedge clk);
            end
            bus_if.redirect = 1'b0;
            chk("halt_no_req",   32'(hits),  32'd0);
            chk("halt_no_valid", 32'(vhits), 32'd0);
            chk("halt_flag",     32'(bus_if.fetch_misalign), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("halt_rst_flag", 32'(bus_if.fetch_misalign), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("halt_restart_req",  32'(bus_if.imem_req), 32'd1);
            chk("halt_restart_addr", bus_if.imem_addr, RESET_PC);
        end else begin
            found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus_if.out_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("mis_resume_seen", 32'(found), 32'd1);
            chk("mis_resume_pc",   bus_if.out_pc, 32'h100);
            chk("mis_resume_flag", 32'(bus_if.fetch_misalign), 32'd0);
        end

        // ---- reset asserted mid-wait with three entries queued ----
        do_reset(3);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_if.imem_req && !bus_if.imem_ack && bus_if.imem_addr == 32'hC) begin
                found = 1'b1;
                break;
            end
        end
        chk("midrst_seen",  32'(found), 32'd1);
        chk("midrst_valid", 32'(bus_if.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid0", 32'(bus_if.out_valid), 32'd0);
        chk("midrst_req0",   32'(bus_if.imem_req),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_refetch_req",  32'(bus_if.imem_req), 32'd1);
        chk("midrst_refetch_addr", bus_if.imem_addr, RESET_PC);

        // ---- randomized run against the reference model ----
        salt     = 32'h1234_0000;
        mem_rand = 1'b1;
        do_reset(0);
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            model_check();
            bus_if.out_ready = ($urandom_range(0, 1) == 1);
            bus_if.redirect  = ($urandom_range(0, 15) == 0);
            rpc = $urandom();
            if (MIS_EN) rpc[1:0] = 2'b00;
            bus_if.redirect_pc = rpc;
            #1;
            model_step();
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch_queue
`default_nettype wire
